// File: rtl/regfile_pkg.sv
// Shared constants and FSM state type for the register-file writeback arbiter.
package regfile_pkg;
  localparam int XLEN_DEF       = 32;
  localparam int REG_ADDR_W     = 5;
  localparam int NUM_REGS       = 32;
  localparam int NUM_WB_REQ_DEF = 3;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: one-hot grant to the first requester at or after ptr.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates NUM_REQ writeback requesters onto one register-file write port.
// Optional zeroing sweep of x1..x31 after reset is enabled by RF_INIT_SWEEP_EN.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = NUM_WB_REQ_DEF,
  parameter int XLEN    = XLEN_DEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [REG_ADDR_W*NUM_REQ-1:0]   req_rd,
  input  logic [XLEN*NUM_REQ-1:0]         req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            rf_we,
  output logic [REG_ADDR_W-1:0]           rf_rd,
  output logic [XLEN-1:0]                 rf_wdata,
  output logic                            init_done
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  rf_state_e              state_q, state_d;
  logic                   init_done_q, init_done_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic                   rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0]  rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]        rf_wdata_q, rf_wdata_d;
`ifdef RF_INIT_SWEEP_EN
  logic [REG_ADDR_W-1:0]  cnt_q, cnt_d;
`endif

  logic [NUM_REQ-1:0]     gnt;
  logic                   grant_en;
  logic                   xfer;
  logic [PW-1:0]          win_idx;
  logic [REG_ADDR_W-1:0]  win_rd;
  logic [XLEN-1:0]        win_data;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  // Grants are only live once the file is initialised; reset forces this low.
  assign grant_en  = (state_q == RUN) && init_done_q;
  assign req_ready = grant_en ? gnt : '0;
  assign xfer      = |req_ready;

  always_comb begin
    win_idx  = '0;
    win_rd   = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        win_idx  = PW'(i);
        win_rd   = req_rd[REG_ADDR_W*i +: REG_ADDR_W];
        win_data = req_data[XLEN*i +: XLEN];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    init_done_d = init_done_q;
    ptr_d       = ptr_q;
    rf_we_d     = 1'b0;
    rf_rd_d     = rf_rd_q;
    rf_wdata_d  = rf_wdata_q;
`ifdef RF_INIT_SWEEP_EN
    cnt_d       = cnt_q;
    if (state_q == INIT) begin
      // cnt wraps 31 -> 0; zero marks the sweep as finished.
      if (cnt_q != '0) begin
        rf_we_d    = 1'b1;
        rf_rd_d    = cnt_q;
        rf_wdata_d = '0;
        cnt_d      = cnt_q + 1'b1;
      end else begin
        state_d     = RUN;
        init_done_d = 1'b1;
      end
    end else begin
`else
    begin
      init_done_d = 1'b1;
`endif
      if (xfer) begin
        ptr_d = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        // A write to x0 is accepted but never reaches the file.
        if (win_rd != '0) begin
          rf_we_d    = 1'b1;
          rf_rd_d    = win_rd;
          rf_wdata_d = win_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef RF_INIT_SWEEP_EN
      state_q     <= INIT;
      cnt_q       <= REG_ADDR_W'(1);
`else
      state_q     <= RUN;
`endif
      init_done_q <= 1'b0;
      ptr_q       <= '0;
      rf_we_q     <= 1'b0;
      rf_rd_q     <= '0;
      rf_wdata_q  <= '0;
    end else begin
`ifdef RF_INIT_SWEEP_EN
      cnt_q       <= cnt_d;
`endif
      state_q     <= state_d;
      init_done_q <= init_done_d;
      ptr_q       <= ptr_d;
      rf_we_q     <= rf_we_d;
      rf_rd_q     <= rf_rd_d;
      rf_wdata_q  <= rf_wdata_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_rd     = rf_rd_q;
  assign rf_wdata  = rf_wdata_q;
  assign init_done = init_done_q;

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, the number of writeback requesters sharing the register-file write port.
REQ-002 SHALL have parameter XLEN, default 32, the data width.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  NUM_REQ  per-requester write request.
REQ-007 req_rd  input  5*NUM_REQ  destination register per requester; requester i occupies bits [5i+4:5i].
REQ-008 req_data  input  XLEN*NUM_REQ  write data per requester; requester i occupies bits [XLEN*i+XLEN-1:XLEN*i].
REQ-009 req_ready  output  NUM_REQ  one-hot grant/accept per requester.
REQ-010 rf_we  output  1  register-file RegWrite.
REQ-011 rf_rd  output  5  register-file Rd.
REQ-012 rf_wdata  output  XLEN  register-file Write_data.
REQ-013 init_done  output  1  high once the register file is initialised and arbitration is live.

Function
REQ-014 SHALL implement a two-state FSM with states INIT and RUN.
REQ-015 In INIT, SHALL drive one write per cycle: rf_we=1, rf_wdata=0, rf_rd sweeping 1,2,...,31; req_ready=0 throughout.
REQ-016 After the Rd=31 write, SHALL enter RUN on the next cycle and set init_done=1; the sweep lasts exactly 31 cycles.
REQ-017 In RUN, SHALL assert at most one req_ready bit, combinationally, to the first valid requester at or after the round-robin pointer.
REQ-018 A transfer SHALL occur when req_valid[i] and req_ready[i] are both high; requesters hold valid, rd and data stable until they are accepted.
REQ-019 On a transfer, SHALL register rf_we=1, rf_rd=req_rd[i], rf_wdata=req_data[i] at the next clock edge; write latency is 1 cycle.
REQ-020 With no transfer, rf_we SHALL be 0 the following cycle; rf_rd and rf_wdata hold their previous values.
REQ-021 A request with rd=0 SHALL be accepted (ready high) but SHALL produce rf_we=0: the x0 write is discarded.
REQ-022 After a transfer to requester i, the pointer SHALL become (i+1) mod NUM_REQ; with no transfer, the pointer SHALL be unchanged.
REQ-023 When two requesters target the same rd in the same cycle, SHALL accept only the round-robin winner; the loser waits and writes in a later cycle, so the last write wins.
REQ-024 The register file SHALL never be backpressured: one write accepted per cycle at most, sustained.

Reset
REQ-025 While rst_n=0, SHALL hold rf_we=0, rf_rd=0, rf_wdata=0, req_ready=0, init_done=0, pointer=0 and state=INIT (or RUN without the macro), taking effect immediately and independent of clk.
REQ-026 On reset assertion mid-sweep or mid-transfer, SHALL abandon the operation; after release, a full sweep restarts from Rd=1.

Configuration
REQ-027 Macro RF_INIT_SWEEP_EN: when defined, the INIT sweep of REQ-015/016 SHALL be compiled in.
REQ-028 When RF_INIT_SWEEP_EN is undefined, reset SHALL enter RUN directly, init_done SHALL be 1 from the first cycle after reset release, and no sweep logic SHALL exist.

Structure
REQ-029 Package regfile_pkg SHALL hold XLEN_DEF=32, REG_ADDR_W=5, NUM_REGS=32, NUM_WB_REQ_DEF=3, and the FSM state enum (INIT, RUN).
REQ-030 Sub-module rr_arbiter (parameter N; inputs req, ptr; output one-hot gnt) SHALL implement the round-robin grant; the top level owns the pointer register, FSM and output registers.

Verification
REQ-031 Reset release with RF_INIT_SWEEP_EN: rf_we=1 for 31 cycles with rf_rd=1..31 and rf_wdata=0 -> init_done rises on cycle 32; a req_valid asserted during the sweep sees ready=0.
REQ-032 RUN, all three valid constantly with pointer 0: grants 0,1,2,0,1,2 on consecutive cycles -> rf_rd/rf_wdata follow one cycle later with rf_we held at 1.
REQ-033 req0 rd=0 data=0xDEADBEEF -> ready0=1, next-cycle rf_we=0, pointer advances to 1.
REQ-034 req1 and req2 both rd=5 (data 0x11 and 0x22), pointer 2 -> req2 is written first, then req1 -> final rf write is rd=5, data=0x11.
REQ-035 rst_n pulled low mid-sweep at rf_rd=10 -> outputs zero immediately, no clock needed; after release the sweep restarts at rf_rd=1.
REQ-036 Build without RF_INIT_SWEEP_EN -> init_done=1 one cycle after reset release; a single req0 write (rd=3, data=7) appears as rf_we=1, rf_rd=3, rf_wdata=7 one cycle after acceptance.
